// File: rtl/maze_move_ctrl.sv
// ============================================================================
//  Module   : maze_move_ctrl
//  Purpose  : Player movement sequencer: latches a direction, checks the
//             target cell via a wall-store handshake, then commits or rejects.
//  Option   : MAZE_MOVE_TIMEOUT_EN enables a forced reject after ACK_TIMEOUT
//             WAIT cycles without an ack.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module maze_move_ctrl #(
    parameter int GRID_W      = 32,
    parameter int GRID_H      = 24,
    parameter int START_X     = 1,
    parameter int START_Y     = 1,
    parameter int GOAL_X      = 30,
    parameter int GOAL_Y      = 22,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        move_tick,
    input  logic [3:0]  btn_req,
    output logic        wall_rd_req,
    output logic [7:0]  wall_rd_x,
    output logic [7:0]  wall_rd_y,
    input  logic        wall_rd_ack,
    input  logic        wall_rd_data,
    output logic [7:0]  player_x_pos,
    output logic [7:0]  player_y_pos,
    output logic [15:0] move_count,
    output logic        blocked,
    output logic        won
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam logic [1:0] DIR_U = 2'd0;
    localparam logic [1:0] DIR_D = 2'd1;
    localparam logic [1:0] DIR_L = 2'd2;
    localparam logic [1:0] DIR_R = 2'd3;

    localparam logic [8:0] C_GRID_W  = 9'(GRID_W);
    localparam logic [8:0] C_GRID_H  = 9'(GRID_H);
    localparam logic [7:0] C_START_X = 8'(START_X);
    localparam logic [7:0] C_START_Y = 8'(START_Y);
    localparam logic [7:0] C_GOAL_X  = 8'(GOAL_X);
    localparam logic [7:0] C_GOAL_Y  = 8'(GOAL_Y);

    state_t      state_q;
    logic        pend_vld_q;
    logic [1:0]  pend_dir_q;
    logic        wall_rd_req_q;
    logic [7:0]  wall_rd_x_q;
    logic [7:0]  wall_rd_y_q;
    logic [7:0]  player_x_q;
    logic [7:0]  player_y_q;
    logic [15:0] move_count_q;
    logic        blocked_q;
    logic        won_q;

    logic [1:0]  btn_dir;
    logic        btn_any;
    logic [8:0]  tgt_x;
    logic [8:0]  tgt_y;
    logic        tgt_oob;
    logic        at_goal;
    logic        timeout_hit;

    assign btn_any = |btn_req;

    always_comb begin
        btn_dir = DIR_R;
        if (btn_req[3]) begin
            btn_dir = DIR_U;
        end else if (btn_req[2]) begin
            btn_dir = DIR_D;
        end else if (btn_req[1]) begin
            btn_dir = DIR_L;
        end
    end

    // 9-bit two's complement: stepping left/up from 0 sets bit 8 (negative).
    always_comb begin
        tgt_x = {1'b0, player_x_q};
        tgt_y = {1'b0, player_y_q};
        case (pend_dir_q)
            DIR_U:   tgt_y = {1'b0, player_y_q} - 9'd1;
            DIR_D:   tgt_y = {1'b0, player_y_q} + 9'd1;
            DIR_L:   tgt_x = {1'b0, player_x_q} - 9'd1;
            default: tgt_x = {1'b0, player_x_q} + 9'd1;
        endcase
    end

    assign tgt_oob = tgt_x[8] | tgt_y[8] | (tgt_x >= C_GRID_W) | (tgt_y >= C_GRID_H);
    assign at_goal = (wall_rd_x_q == C_GOAL_X) && (wall_rd_y_q == C_GOAL_Y);

`ifdef MAZE_MOVE_TIMEOUT_EN
    localparam int TO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    logic [TO_W-1:0] to_cnt_q;
    assign timeout_hit = (to_cnt_q == TO_W'(ACK_TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            pend_vld_q    <= 1'b0;
            pend_dir_q    <= DIR_U;
            wall_rd_req_q <= 1'b0;
            wall_rd_x_q   <= 8'd0;
            wall_rd_y_q   <= 8'd0;
            player_x_q    <= C_START_X;
            player_y_q    <= C_START_Y;
            move_count_q  <= 16'd0;
            blocked_q     <= 1'b0;
            won_q         <= 1'b0;
`ifdef MAZE_MOVE_TIMEOUT_EN
            to_cnt_q      <= '0;
`endif
        end else begin
            blocked_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (move_tick && pend_vld_q && !won_q) begin
                        if (tgt_oob) begin
                            blocked_q  <= 1'b1;
                            pend_vld_q <= 1'b0;
                        end else begin
                            wall_rd_req_q <= 1'b1;
                            wall_rd_x_q   <= tgt_x[7:0];
                            wall_rd_y_q   <= tgt_y[7:0];
                            state_q       <= ST_WAIT;
`ifdef MAZE_MOVE_TIMEOUT_EN
                            to_cnt_q      <= '0;
`endif
                        end
                    end else if (!pend_vld_q && !won_q && btn_any) begin
                        pend_vld_q <= 1'b1;
                        pend_dir_q <= btn_dir;
                    end
                end
                ST_WAIT: begin
                    if (wall_rd_ack) begin
                        wall_rd_req_q <= 1'b0;
                        pend_vld_q    <= 1'b0;
                        state_q       <= ST_IDLE;
                        if (wall_rd_data) begin
                            blocked_q <= 1'b1;
                        end else begin
                            player_x_q <= wall_rd_x_q;
                            player_y_q <= wall_rd_y_q;
                            if (move_count_q != 16'hFFFF) begin
                                move_count_q <= move_count_q + 16'd1;
                            end
                            if (at_goal) begin
                                won_q <= 1'b1;
                            end
                        end
                    end else if (timeout_hit) begin
                        // Unanswered lookup is rejected exactly like a wall.
                        blocked_q     <= 1'b1;
                        wall_rd_req_q <= 1'b0;
                        pend_vld_q    <= 1'b0;
                        state_q       <= ST_IDLE;
                    end else begin
`ifdef MAZE_MOVE_TIMEOUT_EN
                        to_cnt_q <= to_cnt_q + 1'b1;
`endif
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign wall_rd_req  = wall_rd_req_q;
    assign wall_rd_x    = wall_rd_x_q;
    assign wall_rd_y    = wall_rd_y_q;
    assign player_x_pos = player_x_q;
    assign player_y_pos = player_y_q;
    assign move_count   = move_count_q;
    assign blocked      = blocked_q;
    assign won          = won_q;

endmodule

`default_nettype wire

// File: tb/tb_maze_move_ctrl.sv
// ============================================================================
//  Module   : tb_maze_move_ctrl
//  Purpose  : Self-checking bench for maze_move_ctrl: fixed vector table,
//             directed corner sequences and a randomized model comparison.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_maze_move_ctrl;

    localparam int GRID_W      = 32;
    localparam int GRID_H      = 24;
    localparam int ACK_TIMEOUT = 15;
`ifdef MAZE_MOVE_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        move_tick = 1'b0;
    logic [3:0]  btn_req = 4'd0;
    logic        wall_rd_req;
    logic [7:0]  wall_rd_x;
    logic [7:0]  wall_rd_y;
    logic        wall_rd_ack = 1'b0;
    logic        wall_rd_data = 1'b0;
    logic [7:0]  player_x_pos;
    logic [7:0]  player_y_pos;
    logic [15:0] move_count;
    logic        blocked;
    logic        won;

    maze_move_ctrl #(
        .GRID_W(GRID_W), .GRID_H(GRID_H), .START_X(1), .START_Y(1),
        .GOAL_X(30), .GOAL_Y(22), .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .move_tick(move_tick), .btn_req(btn_req),
        .wall_rd_req(wall_rd_req), .wall_rd_x(wall_rd_x), .wall_rd_y(wall_rd_y),
        .wall_rd_ack(wall_rd_ack), .wall_rd_data(wall_rd_data),
        .player_x_pos(player_x_pos), .player_y_pos(player_y_pos),
        .move_count(move_count), .blocked(blocked), .won(won)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc_no = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference model: direction index 0..3 = U,D,L,R; -1 = nothing pending.
    int DX[4] = '{0, 0, -1, 1};
    int DY[4] = '{-1, 1, 0, 0};
    bit m_wait, m_req, m_blk, m_won;
    int m_pend, m_x, m_y, m_cnt, m_ax, m_ay, m_tcnt;

    task automatic model_reset();
        m_wait = 0; m_req = 0; m_blk = 0; m_won = 0;
        m_pend = -1; m_x = 1; m_y = 1; m_cnt = 0; m_ax = 0; m_ay = 0; m_tcnt = 0;
    endtask

    task automatic model_step(input bit r, input bit t, input logic [3:0] b,
                              input bit a, input bit d);
        int tx, ty;
        if (r) begin
            model_reset();
            return;
        end
        m_blk = 0;
        if (!m_wait) begin
            if (t && m_pend >= 0 && !m_won) begin
                tx = m_x + DX[m_pend];
                ty = m_y + DY[m_pend];
                if (tx < 0 || ty < 0 || tx >= GRID_W || ty >= GRID_H) begin
                    m_blk = 1; m_pend = -1;
                end else begin
                    m_wait = 1; m_req = 1; m_ax = tx; m_ay = ty; m_tcnt = 0;
                end
            end else if (m_pend < 0 && !m_won && b != 4'd0) begin
                for (int i = 3; i >= 0; i--) begin
                    if (b[i]) begin
                        m_pend = 3 - i;
                        break;
                    end
                end
            end
        end else if (a) begin
            m_wait = 0; m_req = 0; m_pend = -1;
            if (d) begin
                m_blk = 1;
            end else begin
                m_x = m_ax; m_y = m_ay;
                m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
                if (m_x == 30 && m_y == 22) m_won = 1;
            end
        end else if (TO_EN) begin
            m_tcnt++;
            if (m_tcnt == ACK_TIMEOUT) begin
                m_wait = 0; m_req = 0; m_pend = -1; m_blk = 1;
            end
        end
    endtask

    // One clock with model tracking and a full output comparison.
    task automatic cyc(input bit r, input bit t, input logic [3:0] b,
                       input bit a, input bit d);
        reset = r; move_tick = t; btn_req = b; wall_rd_ack = a; wall_rd_data = d;
        model_step(r, t, b, a, d);
        @(posedge clk);
        #1;
        cyc_no++;
        chk($sformatf("req@%0d", cyc_no), int'(wall_rd_req), int'(m_req));
        chk($sformatf("rd_x@%0d", cyc_no), int'(wall_rd_x), m_ax);
        chk($sformatf("rd_y@%0d", cyc_no), int'(wall_rd_y), m_ay);
        chk($sformatf("pos_x@%0d", cyc_no), int'(player_x_pos), m_x);
        chk($sformatf("pos_y@%0d", cyc_no), int'(player_y_pos), m_y);
        chk($sformatf("count@%0d", cyc_no), int'(move_count), m_cnt);
        chk($sformatf("blocked@%0d", cyc_no), int'(blocked), int'(m_blk));
        chk($sformatf("won@%0d", cyc_no), int'(won), int'(m_won));
    endtask

    task automatic mv(input int dir, input bit wall);
        cyc(0, 0, 4'b1000 >> dir, 0, 0);
        cyc(0, 1, 4'd0, 0, 0);
        if (m_wait) begin
            repeat ($urandom_range(0, 2)) cyc(0, 0, 4'd0, 0, 0);
            cyc(0, 0, 4'd0, 1, wall);
        end
    endtask

    typedef struct {
        bit rst; bit tick; logic [3:0] btn; bit ack; bit dat;
        bit req; int ax; int ay; int x; int y; int cnt; bit blk; bit wn;
    } vec_t;
    vec_t tv[22];

    initial begin
        //          rst tk btn     ak dt  req ax ay x  y  cnt blk won
        tv[0]  = '{0, 1, 4'b0001, 0, 0,  0, 0, 0, 1, 1, 0, 0, 0};
        tv[1]  = '{0, 1, 4'b0000, 0, 0,  1, 2, 1, 1, 1, 0, 0, 0};
        tv[2]  = '{0, 0, 4'b0000, 0, 0,  1, 2, 1, 1, 1, 0, 0, 0};
        tv[3]  = '{0, 0, 4'b0000, 1, 0,  0, 2, 1, 2, 1, 1, 0, 0};
        tv[4]  = '{0, 0, 4'b0000, 0, 0,  0, 2, 1, 2, 1, 1, 0, 0};
        tv[5]  = '{1, 0, 4'b0000, 0, 0,  0, 0, 0, 1, 1, 0, 0, 0};
        tv[6]  = '{0, 0, 4'b1000, 0, 0,  0, 0, 0, 1, 1, 0, 0, 0};
        tv[7]  = '{0, 1, 4'b0000, 0, 0,  1, 1, 0, 1, 1, 0, 0, 0};
        tv[8]  = '{0, 0, 4'b0000, 1, 1,  0, 1, 0, 1, 1, 0, 1, 0};
        tv[9]  = '{0, 0, 4'b0000, 0, 0,  0, 1, 0, 1, 1, 0, 0, 0};
        tv[10] = '{0, 0, 4'b0010, 0, 0,  0, 1, 0, 1, 1, 0, 0, 0};
        tv[11] = '{0, 1, 4'b0000, 0, 0,  1, 0, 1, 1, 1, 0, 0, 0};
        tv[12] = '{0, 0, 4'b0000, 1, 0,  0, 0, 1, 0, 1, 1, 0, 0};
        tv[13] = '{0, 0, 4'b0010, 0, 0,  0, 0, 1, 0, 1, 1, 0, 0};
        tv[14] = '{0, 1, 4'b0000, 0, 0,  0, 0, 1, 0, 1, 1, 1, 0};
        tv[15] = '{0, 0, 4'b0000, 0, 0,  0, 0, 1, 0, 1, 1, 0, 0};
        tv[16] = '{0, 0, 4'b1111, 0, 0,  0, 0, 1, 0, 1, 1, 0, 0};
        tv[17] = '{0, 1, 4'b0000, 0, 0,  1, 0, 0, 0, 1, 1, 0, 0};
        tv[18] = '{0, 1, 4'b0100, 0, 0,  1, 0, 0, 0, 1, 1, 0, 0};
        tv[19] = '{0, 0, 4'b0000, 1, 1,  0, 0, 0, 0, 1, 1, 1, 0};
        tv[20] = '{0, 1, 4'b0000, 0, 0,  0, 0, 0, 0, 1, 1, 0, 0};
        tv[21] = '{0, 0, 4'b0000, 1, 0,  0, 0, 0, 0, 1, 1, 0, 0};

        model_reset();
        cyc(1, 0, 4'd0, 0, 0);

        for (int i = 0; i < 22; i++) begin
            reset = tv[i].rst; move_tick = tv[i].tick; btn_req = tv[i].btn;
            wall_rd_ack = tv[i].ack; wall_rd_data = tv[i].dat;
            @(posedge clk);
            #1;
            chk($sformatf("tv%0d.req", i), int'(wall_rd_req), int'(tv[i].req));
            chk($sformatf("tv%0d.rd_x", i), int'(wall_rd_x), tv[i].ax);
            chk($sformatf("tv%0d.rd_y", i), int'(wall_rd_y), tv[i].ay);
            chk($sformatf("tv%0d.pos_x", i), int'(player_x_pos), tv[i].x);
            chk($sformatf("tv%0d.pos_y", i), int'(player_y_pos), tv[i].y);
            chk($sformatf("tv%0d.count", i), int'(move_count), tv[i].cnt);
            chk($sformatf("tv%0d.blocked", i), int'(blocked), int'(tv[i].blk));
            chk($sformatf("tv%0d.won", i), int'(won), int'(tv[i].wn));
        end

        // Walk to the goal, then confirm everything is frozen.
        cyc(1, 0, 4'd0, 0, 0);
        repeat (28) mv(3, 0);
        repeat (21) mv(1, 0);
        chk("pre_goal_x", int'(player_x_pos), 29);
        chk("pre_goal_y", int'(player_y_pos), 22);
        mv(3, 0);
        chk("goal_x", int'(player_x_pos), 30);
        chk("goal_won", int'(won), 1);
        chk("goal_count", int'(move_count), 50);
        cyc(0, 0, 4'b0100, 0, 0);
        cyc(0, 1, 4'd0, 0, 0);
        chk("won_no_req", int'(wall_rd_req), 0);
        repeat (3) cyc(0, 1, 4'b0001, 0, 0);

        // Asynchronous reset in the middle of a lookup.
        cyc(1, 0, 4'd0, 0, 0);
        cyc(0, 0, 4'b0001, 0, 0);
        cyc(0, 1, 4'd0, 0, 0);
        chk("wait_req", int'(wall_rd_req), 1);
        reset = 1'b1;
        #1;
        chk("async_rst_req", int'(wall_rd_req), 0);
        chk("async_rst_x", int'(player_x_pos), 1);
        chk("async_rst_won", int'(won), 0);
        model_reset();
        cyc(1, 0, 4'd0, 0, 0);

        // Unanswered lookup followed by a late ack.
        cyc(0, 0, 4'b0001, 0, 0);
        cyc(0, 1, 4'd0, 0, 0);
        repeat (40) cyc(0, 1, 4'd0, 0, 0);
        cyc(0, 0, 4'd0, 1, 0);
        cyc(0, 0, 4'd0, 0, 0);

        // Randomized traffic against the model.
        cyc(1, 0, 4'd0, 0, 0);
        repeat (1500) begin
            bit r, t, a, d;
            logic [3:0] b;
            r = ($urandom_range(0, 299) == 0);
            t = ($urandom_range(0, 2) == 0);
            b = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            a = m_wait ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            d = ($urandom_range(0, 3) == 0);
            cyc(r, t, b, a, d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/maze_move_ctrl.md
Name: maze_move_ctrl

Overview:
- Sequences player movement on the maze grid between the debounced button interface and the on-screen player position consumed by game logic and the VGA renderer.
- Latches one direction request and processes it on a movement tick.
- Looks up the target cell in the maze wall store over a req/ack handshake, then either commits the move or rejects it.
- Tracks move count and a sticky goal-reached flag.

Parameters:
GRID_W, 32, maze width in cells (x range 0..GRID_W-1)
GRID_H, 24, maze height in cells (y range 0..GRID_H-1)
START_X, 1, player x after reset
START_Y, 1, player y after reset
GOAL_X, 30, goal cell x
GOAL_Y, 22, goal cell y
ACK_TIMEOUT, 15, max cycles in WAIT before forced reject (only with the optional feature)

Ports:
clk  in  1  system clock; all state changes on rising edge
reset  in  1  asynchronous, active-high reset
move_tick  in  1  single-cycle enable; pending request is processed only on a tick
btn_req  in  4  single-cycle direction pulses {U,D,L,R}
wall_rd_req  out  1  wall lookup request, held until ack
wall_rd_x  out  8  lookup cell x, stable while wall_rd_req=1
wall_rd_y  out  8  lookup cell y, stable while wall_rd_req=1
wall_rd_ack  in  1  lookup complete, single cycle
wall_rd_data  in  1  1 = target cell is wall
player_x_pos  out  8  current player cell x
player_y_pos  out  8  current player cell y
move_count  out  16  committed moves, saturating
blocked  out  1  one-cycle pulse on a rejected move
won  out  1  sticky; set when player enters goal cell

Behaviour:
- Reset values: player_x_pos=START_X, player_y_pos=START_Y, move_count=0, won=0, blocked=0, wall_rd_req=0, wall_rd_x=0, wall_rd_y=0, pending empty, state IDLE.
- Reset asserted mid-handshake drops wall_rd_req immediately and discards the pending request.
- Pending register holds one direction plus a valid bit.
- Loads only when empty, state is IDLE and won=0.
- Multiple btn_req bits in the same cycle: priority U > D > L > R; the others are dropped.
- btn_req while pending is valid or state is not IDLE is ignored.
- Direction deltas: U is y-1, D is y+1, L is x-1, R is x+1.
- Target is computed in 9-bit signed arithmetic.
- Out of bounds means target < 0, x >= GRID_W or y >= GRID_H.
- States: IDLE, WAIT.
- IDLE with move_tick=1 and pending valid, target out of bounds: blocked=1 next cycle, pending cleared, stay IDLE, no lookup issued.
- IDLE with move_tick=1 and pending valid, target in bounds: the next edge sets wall_rd_req=1, loads wall_rd_x/y with the target, and moves to WAIT.
- IDLE with move_tick=1 and pending empty: nothing happens.
- A btn_req arriving in the same cycle as move_tick (pending empty) is latched and waits for the next tick.
- WAIT: wall_rd_req stays 1 and the address stays stable until wall_rd_ack=1.
- On the ack edge: wall_rd_req drops to 0, pending is cleared, and the state returns to IDLE.
- Ack with wall_rd_data=1: blocked pulses in the following cycle; position is unchanged.
- Ack with wall_rd_data=0: position takes the target (visible the cycle after ack) and move_count increments unless it is 0xFFFF.
- won is set on the same edge when the target equals (GOAL_X, GOAL_Y).
- move_tick is ignored while in WAIT.
- wall_rd_ack while in IDLE is ignored.
- Once won=1, all further requests are ignored until reset; position and move_count are frozen.
- Latency: tick to wall_rd_req is 1 cycle; ack to position update is 1 edge. A lookup with a zero-cycle memory (ack in the first WAIT cycle) completes in 2 cycles from the tick.

Optional Feature:
MAZE_MOVE_TIMEOUT_EN
- Defined: a WAIT-state counter starts at 0 on entry.
- If ACK_TIMEOUT cycles pass with no ack, the move is treated as a wall: blocked pulses, wall_rd_req drops, pending clears, state returns to IDLE.
- A late ack arriving afterwards is ignored.
- Undefined: no counter; WAIT holds indefinitely until ack.

Test Plan:
1. Reset, then btn_req=0001 (R) and move_tick; memory acks 2 cycles later with data=0 -> wall_rd_x=2, wall_rd_y=1 while req=1; then position (2,1), move_count=1, blocked=0.
2. From (1,1), btn_req=1000 (U), tick, ack with data=1 -> blocked high for exactly 1 cycle, position stays (1,1), move_count=0.
3. From reset, btn_req=0010 (L) twice with a commit between -> first move reaches (0,1); second is out of bounds: blocked pulses, wall_rd_req never asserts.
4. btn_req=1111 in one cycle -> U chosen (wall_rd_y=0). A btn_req=0100 issued during WAIT is dropped: the next tick with no new press issues no lookup.
5. Force player to (29,22), press R, ack data=0 -> position (30,22), won=1. A later press D plus tick -> no wall_rd_req, position unchanged. Assert reset during a subsequent WAIT -> wall_rd_req=0 at once, position back to (1,1).
6. With MAZE_MOVE_TIMEOUT_EN and ACK_TIMEOUT=15, press R, tick, never ack -> after 15 WAIT cycles blocked pulses, wall_rd_req=0, state IDLE; an ack injected afterwards changes nothing.
